// File: rtl/data_array_pkg.sv
// Shared types and helpers for the 1R1W cache data array.
package data_array_pkg;

    // Array controller state: sweeping contents to a known value, or serving requests.
    typedef enum logic {
        DA_CLEAR,
        DA_IDLE
    } da_state_t;

    // Write-first merge of one bit: take the new value where its lane is enabled.
    // Used bit by bit across a lane so the bypass path matches the storage write.
    function automatic logic lane_merge(input logic old_bit, input logic new_bit, input logic mask_bit);
        return mask_bit ? new_bit : old_bit;
    endfunction

endpackage

// File: rtl/data_array_1r1w_sram.sv
// Plain 1R1W storage: registered read, lane-masked write, no reset.
// Behavioural model; a hard macro with the same ports can replace it.
module sram_1r1w_mask #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WMASKS = 32
) (
    input  logic                  clk,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WMASKS-1:0] wr_mask_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Masked write and registered read; a same-address read returns the pre-write contents.
    // NOTE: the storage array is deliberately not reset -- RAM macros have no reset, and
    // defined contents after reset come from the clear sweep in the wrapper instead.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int l = 0; l < NUM_WMASKS; l++) begin
                if (wr_mask_i[l]) begin
                    mem_q[wr_addr_i][l*LANE_WIDTH +: LANE_WIDTH] <= wr_data_i[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_array_1r1w.sv
// Cache data array wrapper: clear sweep after reset, write-first bypass,
// registered read-valid, and read data that holds between reads.
module data_array_1r1w
    import data_array_pkg::*;
#(
    parameter int                   DATA_WIDTH     = 256,
    parameter int                   ADDR_WIDTH     = 4,
    parameter int                   NUM_WMASKS     = 32,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WMASKS-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int                  RAM_DEPTH   = 1 << ADDR_WIDTH;
    localparam int                  LANE_WIDTH  = DATA_WIDTH / NUM_WMASKS;
    localparam logic [ADDR_WIDTH:0] LAST_PTR    = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);
    localparam da_state_t           RESET_STATE = CLEAR_ON_RESET ? DA_CLEAR : DA_IDLE;

    da_state_t             state_q;
    logic [ADDR_WIDTH:0]   clr_ptr_q;

    logic                  rd_acc;
    logic                  wr_acc;
    logic                  clearing;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [NUM_WMASKS-1:0] mem_wmask;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  rd_valid_q;
    logic                  byp_hit_q;
    logic [NUM_WMASKS-1:0] byp_mask_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [DATA_WIDTH-1:0] rd_hold_q;
    logic [DATA_WIDTH-1:0] rd_merged;

    assign ready    = (state_q == DA_IDLE);
    assign clearing = (state_q == DA_CLEAR) && !rst;
    assign rd_acc   = ready && rd_en && !rst;
    assign wr_acc   = ready && wr_en && !rst;

    // Controller: sweep every index once after reset, then serve requests until the next reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            clr_ptr_q <= '0;
        end else begin
            case (state_q)
                DA_CLEAR: begin
                    if (clr_ptr_q == LAST_PTR) begin
                        state_q <= DA_IDLE;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                DA_IDLE: begin
                    state_q <= DA_IDLE;
                end
                default: begin
                    state_q <= RESET_STATE;
                end
            endcase
        end
    end

    // Write-port mux: the sweep owns the port while clearing, otherwise the user write.
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wmask = wr_mask;
        mem_wdata = wr_data;
        if (clearing) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q[ADDR_WIDTH-1:0];
            mem_wmask = '1;
            mem_wdata = CLEAR_VALUE;
        end else if (wr_acc) begin
            mem_we = |wr_mask;
        end
    end

    sram_1r1w_mask #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WMASKS (NUM_WMASKS)
    ) u_sram (
        .clk       (clk),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_addr),
        .rd_data_o (mem_rdata),
        .wr_en_i   (mem_we),
        .wr_addr_i (mem_waddr),
        .wr_mask_i (mem_wmask),
        .wr_data_i (mem_wdata)
    );

    // Read-valid, bypass-hit flag and held read data; reset squashes any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            byp_hit_q  <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            rd_valid_q <= rd_acc;
            byp_hit_q  <= rd_acc && wr_acc && (rd_addr == wr_addr);
            if (rd_valid_q) begin
                rd_hold_q <= rd_merged;
            end
        end
    end

    // Capture the colliding write so it can be overlaid on the pre-write storage read.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            byp_mask_q <= wr_mask;
            byp_data_q <= wr_data;
        end
    end

    // Write-first overlay, lane by lane, applied only on a same-address collision.
    for (genvar l = 0; l < NUM_WMASKS; l++) begin : g_lane
        for (genvar b = 0; b < LANE_WIDTH; b++) begin : g_bit
            assign rd_merged[l*LANE_WIDTH+b] = byp_hit_q
                ? lane_merge(mem_rdata[l*LANE_WIDTH+b], byp_data_q[l*LANE_WIDTH+b], byp_mask_q[l])
                : mem_rdata[l*LANE_WIDTH+b];
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? rd_merged : rd_hold_q;

endmodule

// File: tb/tb_data_array_1r1w.sv
// Self-checking bench for data_array_1r1w: scoreboard queue fed at issue time,
// separate monitor pops on every rd_valid and checks the hold value otherwise.
module tb_data_array_1r1w;

    localparam int DW = 256;
    localparam int AW = 4;
    localparam int NM = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NM-1:0] wr_mask;
    logic [DW-1:0] wr_data;

    data_array_1r1w #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_WMASKS     (NM),
        .CLEAR_ON_RESET (1'b1),
        .CLEAR_VALUE    ('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd;
    bit            mon_en = 1'b0;
    int            streak = 0;
    int            streak_max = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-lane write: enabled lanes take the new data, others keep the old.
    function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                                 input logic [NM-1:0] m);
        logic [DW-1:0] r;
        r = old_v;
        for (int l = 0; l < NM; l++) begin
            if (m[l]) r[l*8 +: 8] = new_v[l*8 +: 8];
        end
        return r;
    endfunction

    // Monitor: compare every presented read, and check data holds when no read is presented.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid) begin
                streak++;
                if (streak > streak_max) streak_max = streak;
                if (exp_q.size() == 0) begin
                    check("rd_valid_spurious", DW'(rd_valid), DW'(1'b0));
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
                last_rd = rd_data;
            end else begin
                streak = 0;
                check("rd_data_hold", rd_data, last_rd);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_rd = '0;
        streak  = 0;
        check("reset_rd_valid", DW'(rd_valid), DW'(1'b0));
        check("reset_rd_data", rd_data, '0);
        check("reset_ready", DW'(ready), DW'(1'b0));
        mon_en = 1'b1;
    endtask

    // Counts cycles (from the current point) until ready rises, bounded.
    task automatic wait_ready(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, DW'(n), DW'(exp_cycles));
    endtask

    // One issue cycle; the expected read result is pushed before the edge.
    task automatic op(input logic re, input logic [AW-1:0] ra, input logic we, input logic [AW-1:0] wa,
                      input logic [NM-1:0] m, input logic [DW-1:0] wd);
        logic [DW-1:0] e;
        rd_en   = re;
        rd_addr = ra;
        wr_en   = we;
        wr_addr = wa;
        wr_mask = m;
        wr_data = wd;
        if (ready) begin
            if (re) begin
                e = model[ra];
                if (we && wa == ra) e = apply_mask(e, wd, m);
                exp_q.push_back(e);
            end
            if (we) model[wa] = apply_mask(model[wa], wd, m);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NM-1:0] m;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        last_rd = '0;

        // Sweep: ready low for 16 cycles, then a read of 3 returns 0.
        do_reset();
        wait_ready("sweep_cycles", 16);
        op(1'b1, 4'd3, 1'b0, 4'd0, '0, '0);
        tick(1);

        // Masked write of the low 4 bytes, then read back.
        op(1'b0, 4'd0, 1'b1, 4'd5, 32'h0000_000F, {32{8'hAB}});
        op(1'b1, 4'd5, 1'b0, 4'd0, '0, '0);
        tick(1);

        // Same-cycle read/write to 7: write-first per lane.
        op(1'b0, 4'd0, 1'b1, 4'd7, '1, {32{8'h11}});
        op(1'b1, 4'd7, 1'b1, 4'd7, 32'hFFFF_0000, {32{8'h22}});
        tick(1);
        // Zero mask is a no-op, and the merged contents persisted.
        op(1'b0, 4'd0, 1'b1, 4'd7, '0, '1);
        op(1'b1, 4'd7, 1'b0, 4'd0, '0, '0);
        tick(2);

        // Requests during the sweep are ignored.
        do_reset();
        rd_en = 1'b1; rd_addr = 4'd2;
        wr_en = 1'b1; wr_addr = 4'd2; wr_mask = '1; wr_data = '1;
        wait_ready("ignored_sweep_cycles", 16);
        rd_en = 1'b0;
        wr_en = 1'b0;
        op(1'b1, 4'd2, 1'b0, 4'd0, '0, '0);
        tick(1);

        // Reset in the middle of the sweep restarts it.
        do_reset();
        tick(8);
        do_reset();
        wait_ready("midsweep_restart_cycles", 16);

        // Write data=addr everywhere, then 16 back-to-back reads.
        for (int a = 0; a < DEPTH; a++) op(1'b0, 4'd0, 1'b1, AW'(a), '1, DW'(a));
        streak_max = 0;
        for (int a = 0; a < DEPTH; a++) op(1'b1, AW'(a), 1'b0, 4'd0, '0, '0);
        tick(2);
        check("b2b_valid_run", DW'(streak_max), DW'(16));

        // Randomised traffic on a few addresses to force collisions.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       m = '0;
                1:       m = '1;
                default: m = $urandom();
            endcase
            op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), m, rand_word());
            if ($urandom_range(0, 7) == 0) tick(1);
        end
        tick(3);
        check("scoreboard_drained", DW'(exp_q.size()), DW'(0));

        // Reset while a read is in flight squashes its valid.
        op(1'b1, 4'd1, 1'b0, 4'd0, '0, '0);
        mon_en = 1'b0;
        do_reset();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
